spu_dm_arbiter: RTL and testbench

Arbitrates the single-port 256x8 SPU data memory between the SPU controller (fixed high priority, single-cycle, no handshake) and a host/debug port (four-phase req/ack) used for program-data preload and result readback. Sits between the SPU controller's dm_* outputs and the data memory. A starvation counter tracks denied host cycles. An optional stall path forces a host slot after a configurable wait.

---
 rtl/spu_pkg.sv | 13 +
 rtl/spu_dm_arbiter_if.sv | 32 +++
 rtl/spu_dm_arb_starve_cnt.sv | 26 ++
 rtl/spu_dm_arbiter.sv | 131 +++++++++++++
 tb/tb_spu_dm_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_pkg.sv
// Shared definitions for the SPU data-memory arbiter slice:
// data-memory geometry and the host-port FSM state encoding.
package spu_pkg;

   localparam int unsigned DM_AW = 8;
   localparam int unsigned DM_DW = 8;

   typedef enum logic {
      H_IDLE = 1'b0,
      H_ACK  = 1'b1
   } host_state_t;

endpackage

// File: rtl/spu_dm_arbiter_if.sv
// Host/debug port of the SPU data-memory arbiter: four-phase req/ack
// handshake plus address, write data and registered read data.
// master = host side, slave = arbiter side.
interface spu_dm_arbiter_if;
   import spu_pkg::*;

   logic             host_req;
   logic             host_wr;
   logic [DM_AW-1:0] host_addr;
   logic [DM_DW-1:0] host_w_data;
   logic             host_ack;
   logic [DM_DW-1:0] host_r_data;

   modport master (
      output host_req,
      output host_wr,
      output host_addr,
      output host_w_data,
      input  host_ack,
      input  host_r_data
   );

   modport slave (
      input  host_req,
      input  host_wr,
      input  host_addr,
      input  host_w_data,
      output host_ack,
      output host_r_data
   );

endinterface

// File: rtl/spu_dm_arb_starve_cnt.sv
// Saturating starvation counter: counts denied host cycles up to 'limit'
// and flags when the limit is reached. Clear has priority over increment.
module spu_dm_arb_starve_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   input  logic [7:0] limit,
   output logic       at_limit
);

   logic [7:0] cnt_q;

   // Count register: reset/clear to zero, otherwise step until saturated.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != limit)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   // Flag is decoded from the count register only, so it carries no input path.
   assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/spu_dm_arbiter.sv
// SPU data-memory arbiter. The SPU controller has fixed priority and zero
// latency onto the single-port 256x8 memory; the host/debug port gets the
// memory in free cycles through a four-phase req/ack handshake.
// Optional macro SPU_DM_ARB_STALL_EN: once the host has been denied
// STARVE_LIMIT consecutive cycles, one SPU cycle is stalled and the host
// is forced onto the memory. Without it cpu_stall is tied low and
// host_starved is status only.
module spu_dm_arbiter
   import spu_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   // SPU controller side
   input  logic [DM_AW-1:0] cpu_addr,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   input  logic [DM_DW-1:0] cpu_w_data,
   output logic [DM_DW-1:0] cpu_r_data,
   output logic             cpu_stall,
   // host/debug side
   spu_dm_arbiter_if.slave  host,
   output logic             host_starved,
   // data memory side
   output logic [DM_AW-1:0] mem_addr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [DM_DW-1:0] mem_w_data,
   input  logic [DM_DW-1:0] mem_r_data
);

   host_state_t state_q;
   host_state_t state_d;

   logic cpu_busy;
   logic force_slot;
   logic host_grant;
   logic cnt_inc;
   logic cnt_clr;

   assign cpu_busy = cpu_rd | cpu_wr;

`ifdef SPU_DM_ARB_STALL_EN
   // Forced host slot: starved host still requesting in an idle FSM cycle.
   assign force_slot = ~rst & (state_q == H_IDLE) & host.host_req & host_starved;
`else
   assign force_slot = 1'b0;
`endif

   assign cpu_stall = force_slot;

   // Host owns the memory this cycle; never during reset so nothing replays.
   assign host_grant = ~rst & (state_q == H_IDLE) & host.host_req &
                       (~cpu_busy | force_slot);

   // Denials only count while actually waiting in H_IDLE; a dropped request
   // or a grant restarts the count.
   assign cnt_inc = ~rst & (state_q == H_IDLE) & host.host_req & ~host_grant;
   assign cnt_clr = host_grant | ~host.host_req;

   spu_dm_arb_starve_cnt u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (cnt_inc),
      .clr      (cnt_clr),
      .limit    (8'(STARVE_LIMIT)),
      .at_limit (host_starved)
   );

   // Host FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= H_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Host FSM next state: grant -> ACK, stay in ACK until req is seen low.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         H_IDLE: if (host_grant)     state_d = H_ACK;
         H_ACK:  if (!host.host_req) state_d = H_IDLE;
         default:                    state_d = H_IDLE;
      endcase
   end

   // Host FSM outputs: ack is a pure decode of the state register.
   always_comb begin
      host.host_ack = 1'b0;
      if (state_q == H_ACK) begin
         host.host_ack = 1'b1;
      end
   end

   // Capture memory read data for a granted host read; held through ACK.
   always_ff @(posedge clk) begin
      if (rst) begin
         host.host_r_data <= '0;
      end else if (host_grant && !host.host_wr) begin
         host.host_r_data <= mem_r_data;
      end
   end

   // Memory mux: host on a grant, else SPU when busy, else idle zeros.
   // A simultaneous SPU read+write performs only the write.
   always_comb begin
      mem_addr   = '0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_w_data = '0;
      if (!rst) begin
         if (host_grant) begin
            mem_addr   = host.host_addr;
            mem_wr     = host.host_wr;
            mem_rd     = ~host.host_wr;
            mem_w_data = host.host_w_data;
         end else if (cpu_busy) begin
            mem_addr   = cpu_addr;
            mem_wr     = cpu_wr;
            mem_rd     = cpu_rd & ~cpu_wr;
            mem_w_data = cpu_w_data;
         end
      end
   end

   assign cpu_r_data = mem_r_data;

endmodule

// File: tb/tb_spu_dm_arbiter.sv
// Directed self-checking bench for spu_dm_arbiter (STARVE_LIMIT = 4) with a
// behavioural 256x8 combinational-read memory on the mem_* port.
module tb_spu_dm_arbiter;
   import spu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cpu_addr;
   logic       cpu_rd;
   logic       cpu_wr;
   logic [7:0] cpu_w_data;
   logic [7:0] cpu_r_data;
   logic       cpu_stall;
   logic       host_starved;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic       mem_wr;
   logic [7:0] mem_w_data;
   logic [7:0] mem_r_data;

   logic       pl_we;
   logic [7:0] pl_addr;
   logic [7:0] pl_data;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   spu_dm_arbiter_if hif ();

   spu_dm_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_addr     (cpu_addr),
      .cpu_rd       (cpu_rd),
      .cpu_wr       (cpu_wr),
      .cpu_w_data   (cpu_w_data),
      .cpu_r_data   (cpu_r_data),
      .cpu_stall    (cpu_stall),
      .host         (hif.slave),
      .host_starved (host_starved),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_w_data   (mem_w_data),
      .mem_r_data   (mem_r_data)
   );

   always #5 clk = ~clk;

   // Behavioural data memory with a bench-side preload port.
   logic [7:0] tb_mem [256] = '{default: 8'h00};
   assign mem_r_data = tb_mem[mem_addr];
   always @(posedge clk) begin
      if (mem_wr)     tb_mem[mem_addr] <= mem_w_data;
      else if (pl_we) tb_mem[pl_addr]  <= pl_data;
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
      cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_w_data = d;
   endtask

   task automatic host_drive(input logic req, input logic wr, input logic [7:0] a, input logic [7:0] d);
      hif.host_req = req; hif.host_wr = wr; hif.host_addr = a; hif.host_w_data = d;
   endtask

   task automatic preload();
      logic [7:0] a [4];
      logic [7:0] d [4];
      a = '{8'h30, 8'h31, 8'h32, 8'h40};
      d = '{8'hC3, 8'h3C, 8'hA5, 8'h77};
      for (int i = 0; i < 4; i++) begin
         pl_we = 1'b1; pl_addr = a[i]; pl_data = d[i];
         next();
      end
      pl_we = 1'b0;
   endtask

   task automatic test_reset();
      cpu_drive(1'b0, 1'b1, 8'h77, 8'h99);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++;
         if ({mem_rd, mem_wr} !== 2'b00) begin
            n_fail++; $display("FAIL reset_mem_quiet: rd/wr=%b expected 00", {mem_rd, mem_wr});
         end
         next();
      end
      n_tests++;
      if ({hif.host_ack, host_starved, cpu_stall} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: ack/starved/stall=%b expected 000", {hif.host_ack, host_starved, cpu_stall});
      end
      n_tests++;
      if (hif.host_r_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_r_data: got %h expected 00", hif.host_r_data);
      end
      n_tests++;
      if (dut.state_q !== H_IDLE) begin
         n_fail++; $display("FAIL reset_state: got %b expected H_IDLE", dut.state_q);
      end
      n_tests++;
      if (tb_mem[8'h77] !== 8'h00) begin
         n_fail++; $display("FAIL reset_no_write: mem[77]=%h expected 00", tb_mem[8'h77]);
      end
      rst = 1'b0;
      cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
      next();
   endtask

   task automatic test_host_write_read();
      host_drive(1'b1, 1'b1, 8'h10, 8'h5A);
      #1;
      n_tests++;
      if ({mem_wr, mem_rd, mem_addr, mem_w_data, hif.host_ack} !== {1'b1, 1'b0, 8'h10, 8'h5A, 1'b0}) begin
         n_fail++; $display("FAIL hw_grant: wr=%b rd=%b addr=%h wd=%h ack=%b expected 1 0 10 5a 0",
                            mem_wr, mem_rd, mem_addr, mem_w_data, hif.host_ack);
      end
      next();
      #1;
      n_tests++;
      if ({hif.host_ack, mem_wr} !== 2'b10) begin
         n_fail++; $display("FAIL hw_ack: ack/mem_wr=%b expected 10", {hif.host_ack, mem_wr});
      end
      next();
      host_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if (hif.host_ack !== 1'b1) begin
         n_fail++; $display("FAIL hw_ack_held: ack=%b expected 1", hif.host_ack);
      end
      next();
      #1;
      n_tests++;
      if (hif.host_ack !== 1'b0 || tb_mem[8'h10] !== 8'h5A) begin
         n_fail++; $display("FAIL hw_done: ack=%b mem[10]=%h expected 0 5a", hif.host_ack, tb_mem[8'h10]);
      end
      next();
      host_drive(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      n_tests++;
      if ({mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
         n_fail++; $display("FAIL hr_grant: rd=%b wr=%b addr=%h expected 1 0 10", mem_rd, mem_wr, mem_addr);
      end
      next();
      host_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if (hif.host_ack !== 1'b1 || hif.host_r_data !== 8'h5A) begin
         n_fail++; $display("FAIL hr_data: ack=%b r_data=%h expected 1 5a", hif.host_ack, hif.host_r_data);
      end
      next();
      #1;
      n_tests++;
      if (hif.host_ack !== 1'b0) begin
         n_fail++; $display("FAIL hr_release: ack=%b expected 0", hif.host_ack);
      end
      next();
   endtask

   task automatic test_contention();
      logic [7:0] exp_d [3];
      logic [7:0] a;
      exp_d = '{8'hC3, 8'h3C, 8'hA5};
      host_drive(1'b1, 1'b0, 8'h40, 8'h00);
      for (int i = 0; i < 3; i++) begin
         a = 8'h30 + 8'(i);
         cpu_drive(1'b1, 1'b0, a, 8'h00);
         #1;
         n_tests++;
         if ({cpu_r_data, mem_addr, mem_rd, hif.host_ack} !== {exp_d[i], a, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL cont_deny_%0d: r=%h addr=%h rd=%b ack=%b expected %h %h 1 0",
                               i, cpu_r_data, mem_addr, mem_rd, hif.host_ack, exp_d[i], a);
         end
         next();
      end
      cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if ({mem_rd, mem_addr, hif.host_ack} !== {1'b1, 8'h40, 1'b0}) begin
         n_fail++; $display("FAIL cont_grant: rd=%b addr=%h ack=%b expected 1 40 0", mem_rd, mem_addr, hif.host_ack);
      end
      next();
      host_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if (hif.host_ack !== 1'b1 || hif.host_r_data !== 8'h77) begin
         n_fail++; $display("FAIL cont_data: ack=%b r_data=%h expected 1 77", hif.host_ack, hif.host_r_data);
      end
      next();
      next();
   endtask

   task automatic test_same_addr_write();
      cpu_drive(1'b0, 1'b1, 8'h20, 8'h33);
      host_drive(1'b1, 1'b1, 8'h20, 8'h44);
      #1;
      n_tests++;
      if ({mem_wr, mem_addr, mem_w_data, hif.host_ack} !== {1'b1, 8'h20, 8'h33, 1'b0}) begin
         n_fail++; $display("FAIL conflict_cpu_first: wr=%b addr=%h wd=%h ack=%b expected 1 20 33 0",
                            mem_wr, mem_addr, mem_w_data, hif.host_ack);
      end
      next();
      cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if ({tb_mem[8'h20], mem_wr, mem_addr, mem_w_data} !== {8'h33, 1'b1, 8'h20, 8'h44}) begin
         n_fail++; $display("FAIL conflict_host_next: mem=%h wr=%b addr=%h wd=%h expected 33 1 20 44",
                            tb_mem[8'h20], mem_wr, mem_addr, mem_w_data);
      end
      next();
      host_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if (hif.host_ack !== 1'b1 || tb_mem[8'h20] !== 8'h44) begin
         n_fail++; $display("FAIL conflict_final: ack=%b mem[20]=%h expected 1 44", hif.host_ack, tb_mem[8'h20]);
      end
      next();
      next();
   endtask

   task automatic test_cpu_rw_both();
      cpu_drive(1'b1, 1'b1, 8'h50, 8'hEE);
      #1;
      n_tests++;
      if ({mem_wr, mem_rd, mem_addr} !== {1'b1, 1'b0, 8'h50}) begin
         n_fail++; $display("FAIL rw_both: wr=%b rd=%b addr=%h expected 1 0 50", mem_wr, mem_rd, mem_addr);
      end
      next();
      cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if ({tb_mem[8'h50], mem_wr, mem_rd, mem_addr} !== {8'hEE, 1'b0, 1'b0, 8'h00}) begin
         n_fail++; $display("FAIL rw_idle: mem[50]=%h wr=%b rd=%b addr=%h expected ee 0 0 00",
                            tb_mem[8'h50], mem_wr, mem_rd, mem_addr);
      end
      next();
   endtask

   task automatic test_starve();
      host_drive(1'b1, 1'b0, 8'h10, 8'h00);
      cpu_drive(1'b1, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++;
         if ({host_starved, cpu_stall, hif.host_ack, mem_addr} !== {3'b000, 8'h00}) begin
            n_fail++; $display("FAIL starve_deny_%0d: starved=%b stall=%b ack=%b addr=%h expected 0 0 0 00",
                               i, host_starved, cpu_stall, hif.host_ack, mem_addr);
         end
         next();
      end
`ifdef SPU_DM_ARB_STALL_EN
      #1;
      n_tests++;
      if ({host_starved, cpu_stall, mem_rd, mem_addr} !== {3'b111, 8'h10}) begin
         n_fail++; $display("FAIL starve_force: starved=%b stall=%b rd=%b addr=%h expected 1 1 1 10",
                            host_starved, cpu_stall, mem_rd, mem_addr);
      end
      next();
      host_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if ({cpu_stall, host_starved, hif.host_ack, hif.host_r_data, mem_addr} !== {3'b001, 8'h5A, 8'h00}) begin
         n_fail++; $display("FAIL starve_after: stall=%b starved=%b ack=%b r=%h addr=%h expected 0 0 1 5a 00",
                            cpu_stall, host_starved, hif.host_ack, hif.host_r_data, mem_addr);
      end
      next();
      cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
      next();
`else
      for (int i = 4; i < 7; i++) begin
         #1;
         n_tests++;
         if ({host_starved, cpu_stall, hif.host_ack, mem_addr} !== {3'b100, 8'h00}) begin
            n_fail++; $display("FAIL starve_hold_%0d: starved=%b stall=%b ack=%b addr=%h expected 1 0 0 00",
                               i, host_starved, cpu_stall, hif.host_ack, mem_addr);
         end
         next();
      end
      cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if ({mem_rd, mem_addr, host_starved, cpu_stall} !== {1'b1, 8'h10, 2'b10}) begin
         n_fail++; $display("FAIL starve_grant: rd=%b addr=%h starved=%b stall=%b expected 1 10 1 0",
                            mem_rd, mem_addr, host_starved, cpu_stall);
      end
      next();
      host_drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      n_tests++;
      if ({hif.host_ack, host_starved, hif.host_r_data} !== {2'b10, 8'h5A}) begin
         n_fail++; $display("FAIL starve_after: ack=%b starved=%b r=%h expected 1 0 5a",
                            hif.host_ack, host_starved, hif.host_r_data);
      end
      next();
      next();
`endif
   endtask

   task automatic test_reset_mid();
      host_drive(1'b1, 1'b1, 8'h60, 8'h11);
      #1;
      n_tests++;
      if (mem_wr !== 1'b1) begin
         n_fail++; $display("FAIL rmid_grant: mem_wr=%b expected 1", mem_wr);
      end
      next();
      rst = 1'b1;
      cpu_drive(1'b0, 1'b1, 8'h61, 8'h22);
      #1;
      n_tests++;
      if ({hif.host_ack, mem_wr} !== 2'b10) begin
         n_fail++; $display("FAIL rmid_in_rst: ack=%b mem_wr=%b expected 1 0", hif.host_ack, mem_wr);
      end
      next();
      #1;
      n_tests++;
      if ({hif.host_ack, mem_wr, host_starved} !== 3'b000 || dut.state_q !== H_IDLE || dut.u_starve.cnt_q !== 8'h00) begin
         n_fail++; $display("FAIL rmid_after: ack=%b wr=%b starved=%b state=%b cnt=%h expected 0 0 0 0 00",
                            hif.host_ack, mem_wr, host_starved, dut.state_q, dut.u_starve.cnt_q);
      end
      rst = 1'b0;
      host_drive(1'b0, 1'b0, 8'h00, 8'h00);
      cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
      next();
      #1;
      n_tests++;
      if ({hif.host_ack, mem_wr, tb_mem[8'h60], tb_mem[8'h61]} !== {2'b00, 8'h11, 8'h00}) begin
         n_fail++; $display("FAIL rmid_mem: ack=%b wr=%b mem[60]=%h mem[61]=%h expected 0 0 11 00",
                            hif.host_ack, mem_wr, tb_mem[8'h60], tb_mem[8'h61]);
      end
      next();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      pl_we = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
      cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
      host_drive(1'b0, 1'b0, 8'h00, 8'h00);
      next();
      preload();
      test_reset();
      test_host_write_read();
      test_contention();
      test_same_addr_write();
      test_cpu_rw_both();
      test_starve();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
